// File: rtl/bnn_pkg.sv
// Shared types for the BNN inference controller.
// Holds the FSM state encoding used by the controller and its tests.
package bnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    ERR
  } bnn_ctrl_state_t;

endpackage

// File: rtl/bnn_result_fifo.sv
// First-word-fall-through result FIFO (DEPTH power of 2).
// Ports: push/wdata write, pop/rdata read, full/empty/count status.
module bnn_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bnn_infer_ctrl.sv
// Inference controller: snapshots an image, launches the core,
// times it out, and queues results. Ports: img_* in, core_* to the
// core, res_* FIFO head handshake, busy/done/timeout_err/infer_cnt.
module bnn_infer_ctrl
  import bnn_pkg::*;
#(
  parameter int IMG_W       = 900,
  parameter int HDR_W       = 4,
  parameter int RES_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RES_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IMG_W+HDR_W-1:0] img_in,
  input  logic                   img_valid,
  input  logic                   bnn_enable,
  input  logic                   bnn_clear,
  input  logic                   cont_mode,
  output logic [IMG_W-1:0]       core_img,
  output logic                   core_start,
  input  logic [RES_W-1:0]       core_result,
  input  logic                   core_done,
  output logic [RES_W-1:0]       res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [CNT_W-1:0]       infer_cnt
);

  // One timer serves both the LOAD delay and the RUN timeout.
  localparam int TMR_W = $clog2(TIMEOUT_CYC + SYNC_STAGES + 1);
  localparam logic [TMR_W-1:0] LOAD_LAST = TMR_W'(SYNC_STAGES - 1);
  localparam logic [TMR_W-1:0] RUN_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  bnn_ctrl_state_t    state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [RES_W-1:0]   fifo_rdata;
  logic [$clog2(RES_DEPTH):0] fifo_count;
  logic               unused_ok;

  // Header bits and the raw count are intentionally not consumed.
  assign unused_ok = ^{img_in[HDR_W-1:0], fifo_count};

  assign accept = (state_q == IDLE) && img_valid
                  && bnn_enable && !fifo_full;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    img_d   = img_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          img_d   = img_in[IMG_W+HDR_W-1:HDR_W];
          tmr_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bnn_clear) begin
          state_d = IDLE;
        end else if (tmr_q == LOAD_LAST) begin
          tmr_d   = '0;
          state_d = RUN;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RUN: begin
        // Clear wins over a same-cycle completion.
        if (bnn_clear) begin
          state_d = IDLE;
        end else if (core_done) begin
          push    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = cont_mode ? IDLE : DONE;
        end else if (tmr_q == RUN_LAST) begin
          state_d = ERR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      DONE, ERR: begin
        if (bnn_clear) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      img_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      img_q   <= img_d;
      cnt_q   <= cnt_d;
    end
  end

  bnn_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (res_ready),
    .wdata (core_result),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Start is the first RUN cycle (timer still zero).
  assign core_start  = !rst && (state_q == RUN) && (tmr_q == '0);
  assign core_img    = rst ? '0 : img_q;
  assign res_data    = rst ? '0 : fifo_rdata;
  assign res_valid   = !rst && !fifo_empty;
  assign busy        = !rst && ((state_q == LOAD) || (state_q == RUN));
  assign done        = !rst && (state_q == DONE);
  assign timeout_err = !rst && (state_q == ERR);
  assign infer_cnt   = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Directed bench for bnn_infer_ctrl.
// Runs with TIMEOUT_CYC=16, other parameters at their defaults.
module tb_bnn_infer_ctrl;

  localparam int IMG_W = 900;
  localparam int HDR_W = 4;
  localparam int RES_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [IMG_W+HDR_W-1:0] img_in;
  logic                   img_valid;
  logic                   bnn_enable;
  logic                   bnn_clear;
  logic                   cont_mode;
  logic [IMG_W-1:0]       core_img;
  logic                   core_start;
  logic [RES_W-1:0]       core_result;
  logic                   core_done;
  logic [RES_W-1:0]       res_data;
  logic                   res_valid;
  logic                   res_ready;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;
  logic [15:0]            infer_cnt;

  int n_cmp = 0;
  int n_err = 0;

  bnn_infer_ctrl #(
    .IMG_W       (IMG_W),
    .HDR_W       (HDR_W),
    .RES_W       (RES_W),
    .SYNC_STAGES (2),
    .RES_DEPTH   (4),
    .TIMEOUT_CYC (16),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .img_in      (img_in),
    .img_valid   (img_valid),
    .bnn_enable  (bnn_enable),
    .bnn_clear   (bnn_clear),
    .cont_mode   (cont_mode),
    .core_img    (core_img),
    .core_start  (core_start),
    .core_result (core_result),
    .core_done   (core_done),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .infer_cnt   (infer_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    for (int k = 0; k < 10 && !core_start; k++) tick();
    chk(tag, core_start, 1);
  endtask

  // Accept one image, then complete d cycles after core_start.
  task automatic do_infer(input logic [3:0] r, input int d);
    img_valid = 1'b1;
    tick();
    img_valid = 1'b0;
    chk("acc_busy", busy, 1);
    tick();
    chk("load_nostart", core_start, 0);
    tick();
    chk("start", core_start, 1);
    repeat (d) tick();
    core_done   = 1'b1;
    core_result = r;
    tick();
    core_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; img_in = '0; img_valid = 1'b0; bnn_enable = 1'b1;
    bnn_clear = 1'b0; cont_mode = 1'b0; core_result = '0;
    core_done = 1'b0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_cnt", infer_cnt, 0);
    chk("rst_start", core_start, 0);
    chk("rst_img", core_img[63:0], 0);
    rst = 1'b0;
    tick();

    // 1: single-shot, done 5 cycles after start
    img_in = {899'b0, 1'b1, 4'h0};
    do_infer(4'd7, 5);
    chk("t1_img0", core_img[0], 1);
    chk("t1_done", done, 1);
    chk("t1_valid", res_valid, 1);
    chk("t1_data", res_data, 7);
    chk("t1_cnt", infer_cnt, 1);
    img_valid = 1'b1;
    tick(); tick();
    img_valid = 1'b0;
    chk("t1_hold_done", done, 1);
    chk("t1_ign_busy", busy, 0);
    bnn_clear = 1'b1;
    tick();
    bnn_clear = 1'b0;
    chk("t1_clr_done", done, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t1_pop", res_valid, 0);

    // 2: header strip, then abort in LOAD before start
    img_in = {892'b0, 8'hA5, 4'hF};
    img_valid = 1'b1;
    tick();
    img_valid = 1'b0;
    chk("t2_lo", core_img[63:0], 64'hA5);
    chk("t2_hi", |core_img[IMG_W-1:64], 0);
    tick();
    bnn_clear = 1'b1;
    tick();
    bnn_clear = 1'b0;
    chk("t2_abort_busy", busy, 0);
    chk("t2_no_start", core_start, 0);

    // 3: continuous mode fills the FIFO
    cont_mode = 1'b1;
    img_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_start("t3_start");
      core_done   = 1'b1;
      core_result = 4'(i);
      tick();
      core_done = 1'b0;
    end
    repeat (6) tick();
    chk("t3_full_busy", busy, 0);
    chk("t3_full_start", core_start, 0);
    chk("t3_head", res_data, 1);
    chk("t3_cnt", infer_cnt, 5);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t3_pop_head", res_data, 2);
    chk("t3_pop_busy", busy, 0);
    tick();
    img_valid = 1'b0;
    chk("t3_reaccept", busy, 1);
    wait_start("t3_start5");
    core_done   = 1'b1;
    core_result = 4'd5;
    tick();
    core_done = 1'b0;
    chk("t3_cnt6", infer_cnt, 6);
    res_ready = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      chk("t3_order_v", res_valid, 1);
      chk("t3_order", res_data, 64'(e));
      tick();
    end
    res_ready = 1'b0;
    chk("t3_empty", res_valid, 0);
    cont_mode = 1'b0;

    // 4: timeout
    img_valid = 1'b1;
    tick();
    img_valid = 1'b0;
    tick(); tick();
    chk("t4_start", core_start, 1);
    repeat (15) tick();
    chk("t4_pre_err", timeout_err, 0);
    chk("t4_pre_busy", busy, 1);
    tick();
    chk("t4_err", timeout_err, 1);
    core_done   = 1'b1;
    core_result = 4'd9;
    tick();
    core_done = 1'b0;
    chk("t4_late_valid", res_valid, 0);
    chk("t4_late_cnt", infer_cnt, 6);
    chk("t4_err_hold", timeout_err, 1);
    bnn_clear = 1'b1;
    tick();
    bnn_clear = 1'b0;
    chk("t4_clr", timeout_err, 0);
    chk("t4_clr_busy", busy, 0);

    // 5: clear beats same-cycle done
    img_valid = 1'b1;
    tick();
    img_valid = 1'b0;
    tick(); tick();
    tick(); tick();
    core_done   = 1'b1;
    core_result = 4'd9;
    bnn_clear   = 1'b1;
    tick();
    core_done = 1'b0;
    bnn_clear = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_valid", res_valid, 0);
    chk("t5_cnt", infer_cnt, 6);

    // 6: reset mid-RUN
    do_infer(4'd3, 0);
    chk("t6_pre_valid", res_valid, 1);
    chk("t6_pre_cnt", infer_cnt, 7);
    bnn_clear = 1'b1;
    tick();
    bnn_clear = 1'b0;
    img_valid = 1'b1;
    tick();
    img_valid = 1'b0;
    tick(); tick(); tick();
    chk("t6_run", busy, 1);
    rst = 1'b1;
    tick();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_cnt", infer_cnt, 0);
    chk("t6_rst_img", core_img[63:0], 0);
    chk("t6_rst_start", core_start, 0);
    rst = 1'b0;
    tick();
    chk("t6_post_valid", res_valid, 0);
    chk("t6_post_busy", busy, 0);
    do_infer(4'hA, 1);
    chk("t6_done", done, 1);
    chk("t6_data", res_data, 4'hA);
    chk("t6_cnt", infer_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
